univ_shift_reg: RTL and testbench

Parametrised universal shift register, the multi-bit successor to the team's dual D flip-flop models. It extends per-bit D storage with complementary outputs to a WIDTH-bit register with hold, shift in either direction, rotate, and parallel-load modes. It adds synchronous clear/set and a clock enable. It sits in the 74-series logic library as the generic replacement for '194/'299-style parts and as the storage element for later counter and serial-link blocks.

---
 rtl/hc_lib_pkg.sv | 9 +
 rtl/usr_next.sv | 34 +++
 rtl/univ_shift_reg.sv | 57 +++++
 tb/tb_univ_shift_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hc_lib_pkg.sv
// rtl/hc_lib_pkg.sv - shared mode constants for the 74-series successor blocks
package hc_lib_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_next.sv
// rtl/usr_next.sv - next-state logic for the universal shift register
module usr_next
    import hc_lib_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       s,
    input  logic             rot,
    input  logic             dsu,
    input  logic             dsd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    logic up_in;
    logic down_in;

    // Rotate feeds the bit falling off the far end back in; otherwise the serial pin.
    assign up_in   = rot ? q[WIDTH-1] : dsu;
    assign down_in = rot ? q[0]       : dsd;

    // Mode decode: every S value is covered, hold keeps Q unchanged.
    always_comb begin
        q_next = q;
        case (s)
            MODE_HOLD: q_next = q;
            MODE_UP:   q_next = {q[WIDTH-2:0], up_in};
            MODE_DOWN: q_next = {down_in, q[WIDTH-1:1]};
            MODE_LOAD: q_next = d;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal shift register with clear/set/enable
module univ_shift_reg
    import hc_lib_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             CE,
    input  logic             Clr,
    input  logic             Set,
    input  logic [1:0]       S,
    input  logic             Rot,
    input  logic             DSU,
    input  logic             DSD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic             SOU,
    output logic             SOD
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;

    usr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q_r),
        .s      (S),
        .rot    (Rot),
        .dsu    (DSU),
        .dsd    (DSD),
        .d      (D),
        .q_next (q_next)
    );

    // Priority register: Rst, then Clr (beats Set), then Set, then the enabled mode update.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q_r <= INIT;
        end else if (Clr) begin
            q_r <= '0;
        end else if (Set) begin
            q_r <= '1;
        end else if (CE) begin
            q_r <= q_next;
        end
    end

    assign Q   = q_r;
    assign Q_N = ~q_r;
    assign SOU = q_r[WIDTH-1];
    assign SOD = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg
module tb_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'h3C;

    logic       Clk = 1'b0;
    logic       Rst, CE, Clr, Set, Rot, DSU, DSD;
    logic [1:0] S;
    logic [7:0] D;
    logic [7:0] Q, Q_N;
    logic       SOU, SOD;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_q;

    univ_shift_reg #(
        .WIDTH (W),
        .INIT  (INIT)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .CE  (CE),
        .Clr (Clr),
        .Set (Set),
        .S   (S),
        .Rot (Rot),
        .DSU (DSU),
        .DSD (DSD),
        .D   (D),
        .Q   (Q),
        .Q_N (Q_N),
        .SOU (SOU),
        .SOD (SOD)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv)
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        else
            passes++;
    endtask

    task automatic check_all(input string name, input logic [7:0] e);
        check({name, "_q"},   Q,           e);
        check({name, "_qn"},  Q_N,         ~e);
        check({name, "_sou"}, {7'd0, SOU}, {7'd0, e[7]});
        check({name, "_sod"}, {7'd0, SOD}, {7'd0, e[0]});
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic clr, input logic set,
                                            input logic ce, input logic [1:0] s, input logic rot,
                                            input logic dsu, input logic dsd, input logic [7:0] d);
        logic [7:0] r;
        r = cur;
        if (clr)      r = 8'h00;
        else if (set) r = 8'hFF;
        else if (ce) begin
            if (s == 2'b11) r = d;
            else if (s == 2'b01) begin
                for (int i = 7; i > 0; i--) r[i] = cur[i-1];
                r[0] = rot ? cur[7] : dsu;
            end else if (s == 2'b10) begin
                for (int i = 0; i < 7; i++) r[i] = cur[i+1];
                r[7] = rot ? cur[0] : dsd;
            end
        end
        return r;
    endfunction

    // Drive one cycle of controls at the falling edge and queue the value expected after the next rising edge.
    task automatic step(input logic ce, input logic clr, input logic set, input logic [1:0] s,
                        input logic rot, input logic dsu, input logic dsd, input logic [7:0] d,
                        input logic [7:0] e);
        @(negedge Clk);
        CE = ce; Clr = clr; Set = set; S = s; Rot = rot; DSU = dsu; DSD = dsd; D = d;
        exp_q.push_back(e);
        model_q = e;
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("sb", e);
            end
        end
    end

    initial begin
        logic [7:0] rot_seq [8];
        logic       r_ce, r_clr, r_set, r_rot, r_dsu, r_dsd;
        logic [1:0] r_s;
        logic [7:0] r_d;
        int         wait_cnt;

        rot_seq = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

        Rst = 1'b1; CE = 1'b0; Clr = 1'b0; Set = 1'b0; S = 2'b00;
        Rot = 1'b0; DSU = 1'b0; DSD = 1'b0; D = 8'h00;
        #1;
        check_all("reset", 8'h3C);

        @(negedge Clk);
        Rst = 1'b0;
        step(1, 0, 0, 2'b11, 0, 0, 0, 8'hA5, 8'hA5);
        @(posedge Clk); #2;
        check("sou_before_up", {7'd0, SOU}, 8'h01);
        step(1, 0, 0, 2'b01, 0, 1, 0, 8'h00, 8'h4B);
        step(1, 0, 0, 2'b11, 0, 0, 0, 8'hA5, 8'hA5);
        step(1, 0, 0, 2'b10, 0, 0, 0, 8'h00, 8'h52);

        step(1, 0, 0, 2'b11, 0, 0, 0, 8'h81, 8'h81);
        step(1, 0, 0, 2'b01, 1, 0, 0, 8'h00, 8'h03);
        step(1, 0, 0, 2'b11, 0, 0, 0, 8'h81, 8'h81);
        step(1, 0, 0, 2'b10, 1, 0, 0, 8'h00, 8'hC0);
        step(1, 0, 0, 2'b11, 0, 0, 0, 8'h81, 8'h81);
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 2'b01, 1, 0, 0, 8'h00, rot_seq[i]);

        step(0, 0, 0, 2'b11, 0, 0, 0, 8'hFF, 8'h81);
        step(0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 8'hFF);
        step(0, 1, 1, 2'b00, 0, 0, 0, 8'h00, 8'h00);

        step(1, 0, 0, 2'b11, 0, 0, 0, 8'h81, 8'h81);
        step(1, 0, 0, 2'b01, 0, 0, 0, 8'h00, 8'h02);
        @(posedge Clk); #3;
        Rst = 1'b1;
        #1;
        check_all("mid_rst", 8'h3C);
        step(1, 0, 0, 2'b01, 0, 0, 0, 8'h00, 8'h78);
        Rst = 1'b0;

        for (int n = 0; n < 10000; n++) begin
            r_ce  = ($urandom_range(0, 7) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_set = ($urandom_range(0, 15) == 0);
            r_s   = 2'($urandom_range(0, 3));
            r_rot = 1'($urandom_range(0, 1));
            r_dsu = 1'($urandom_range(0, 1));
            r_dsd = 1'($urandom_range(0, 1));
            r_d   = 8'($urandom_range(0, 255));
            step(r_ce, r_clr, r_set, r_s, r_rot, r_dsu, r_dsd, r_d,
                 ref_next(model_q, r_clr, r_set, r_ce, r_s, r_rot, r_dsu, r_dsd, r_d));
        end

        @(negedge Clk);
        CE = 1'b0; Clr = 1'b0; Set = 1'b0; S = 2'b00;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge Clk); #2;
            wait_cnt++;
        end
        check("drain_queue", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
